// File: rtl/sgt_serial_pkg.sv
// Shared types and constants for the bit-serial signed greater-than comparator.
package sgt_serial_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit-position counter width, with the operand width clamped to the legal range
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned wc;
    wc = (w < WIDTH_MIN) ? WIDTH_MIN : ((w > WIDTH_MAX) ? WIDTH_MAX : w);
    return $clog2(wc);
  endfunction

endpackage

// File: rtl/sgt_shift_reg.sv
// Parallel-load, right-shift register exposing only its LSB; LOAD beats SHIFT.
module sgt_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic             SHIFT,
  input  logic [WIDTH-1:0] D,
  output logic             Q0
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (LOAD) begin
      sr_d = D;
    end else if (SHIFT) begin
      sr_d = {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign Q0 = sr_q[0];

endmodule

// File: rtl/sgt_serial.sv
// Bit-serial signed I0 > I1 comparator, LSB first, one result per WIDTH+1 clocks.
// Optional EQ output is built when SGT_SERIAL_EQ_EN is defined.
module sgt_serial
  import sgt_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  output logic             BUSY,
  output logic             VALID,
  output logic             O
`ifdef SGT_SERIAL_EQ_EN
  ,
  output logic             EQ
`endif
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gt_q, gt_d;
  logic             o_q, o_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             accept, last, a_bit, b_bit;

  assign accept = START && (state_q != SHIFT);
  assign last   = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

  sgt_shift_reg #(.WIDTH(WIDTH)) u_a (
    .CLK(CLK), .RESET(RESET), .LOAD(accept), .SHIFT(state_q == SHIFT), .D(I0), .Q0(a_bit)
  );

  sgt_shift_reg #(.WIDTH(WIDTH)) u_b (
    .CLK(CLK), .RESET(RESET), .LOAD(accept), .SHIFT(state_q == SHIFT), .D(I1), .Q0(b_bit)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = START ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (state_d == SHIFT);
    valid_d = (state_d == DONE);
  end

`ifdef SGT_SERIAL_EQ_EN
  logic eq_q, eq_d, eq_o_q, eq_o_d;
`endif

  // Sign-bit cycle inverts the rule: a set sign bit in A means A is the smaller one
  always_comb begin
    gt_d  = gt_q;
    cnt_d = cnt_q;
    o_d   = o_q;
`ifdef SGT_SERIAL_EQ_EN
    eq_d   = eq_q;
    eq_o_d = eq_o_q;
`endif
    if (accept) begin
      gt_d  = 1'b0;
      cnt_d = '0;
`ifdef SGT_SERIAL_EQ_EN
      eq_d  = 1'b1;
`endif
    end else if (state_q == SHIFT) begin
      if (a_bit != b_bit) begin
        gt_d = last ? b_bit : a_bit;
`ifdef SGT_SERIAL_EQ_EN
        eq_d = 1'b0;
`endif
      end
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      if (last) begin
        o_d = gt_d;
`ifdef SGT_SERIAL_EQ_EN
        eq_o_d = eq_d;
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      o_q     <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

`ifdef SGT_SERIAL_EQ_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      eq_q   <= 1'b0;
      eq_o_q <= 1'b0;
    end else begin
      eq_q   <= eq_d;
      eq_o_q <= eq_o_d;
    end
  end

  assign EQ = eq_o_q;
`endif

  assign BUSY  = busy_q;
  assign VALID = valid_q;
  assign O     = o_q;

endmodule

// File: tb/tb_sgt_serial.sv
// Scoreboard bench for sgt_serial at WIDTH=2 and WIDTH=8.
module tb_sgt_serial;

  typedef struct {
    logic o;
    logic eq;
    int   cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst2, st2, rst8, st8;
  logic [1:0] a2, b2;
  logic [7:0] a8, b8;
  logic       busy2, v2, o2, busy8, v8, o8;
`ifdef SGT_SERIAL_EQ_EN
  logic       eq2, eq8;
`endif

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t q2[$];
  exp_t q8[$];

  logic [7:0] bba [3];
  logic [7:0] bbb [3];
  logic       bbo [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sgt_serial #(.WIDTH(2)) u_dut2 (
    .CLK(clk), .RESET(rst2), .START(st2), .I0(a2), .I1(b2),
    .BUSY(busy2), .VALID(v2), .O(o2)
`ifdef SGT_SERIAL_EQ_EN
    , .EQ(eq2)
`endif
  );

  sgt_serial #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RESET(rst8), .START(st8), .I0(a8), .I1(b8),
    .BUSY(busy8), .VALID(v8), .O(o8)
`ifdef SGT_SERIAL_EQ_EN
    , .EQ(eq8)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon2
    exp_t e;
    if (v2) begin
      if (q2.size() == 0) begin
        chk("unexpected_valid2", 32'(v2), 32'd0);
      end else begin
        e = q2.pop_front();
        chk("o2", 32'(o2), 32'(e.o));
        chk("valid2_cycle", 32'(cyc), 32'(e.cyc));
`ifdef SGT_SERIAL_EQ_EN
        chk("eq2", 32'(eq2), 32'(e.eq));
`endif
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (v8) begin
      if (q8.size() == 0) begin
        chk("unexpected_valid8", 32'(v8), 32'd0);
      end else begin
        e = q8.pop_front();
        chk("o8", 32'(o8), 32'(e.o));
        chk("valid8_cycle", 32'(cyc), 32'(e.cyc));
`ifdef SGT_SERIAL_EQ_EN
        chk("eq8", 32'(eq8), 32'(e.eq));
`endif
      end
    end
  end

  task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic o);
    a2 = a; b2 = b; st2 = 1'b1;
    q2.push_back('{o, 1'b0, cyc + 3});
    tick();
    st2 = 1'b0; a2 = ~a; b2 = ~b;
    repeat (4) tick();
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic o, input logic e);
    a8 = a; b8 = b; st8 = 1'b1;
    q8.push_back('{o, e, cyc + 9});
    tick();
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    repeat (10) tick();
  endtask

  initial begin
    bba[0] = 8'h03; bbb[0] = 8'hFD; bbo[0] = 1'b1;
    bba[1] = 8'hC0; bbb[1] = 8'h9C; bbo[1] = 1'b1;
    bba[2] = 8'h12; bbb[2] = 8'h34; bbo[2] = 1'b0;

    rst2 = 1'b1; rst8 = 1'b1; st2 = 1'b0; st8 = 1'b0;
    a2 = '0; b2 = '0; a8 = '0; b8 = '0;
    repeat (3) tick();
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_valid2", 32'(v2), 32'd0);
    chk("rst_o2", 32'(o2), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_valid8", 32'(v8), 32'd0);
    chk("rst_o8", 32'(o8), 32'd0);
`ifdef SGT_SERIAL_EQ_EN
    chk("rst_eq8", 32'(eq8), 32'd0);
`endif
    rst2 = 1'b0; rst8 = 1'b0;
    tick();

    // WIDTH=2: +1 > -2, with BUSY/VALID shape checked cycle by cycle
    a2 = 2'b01; b2 = 2'b10; st2 = 1'b1;
    q2.push_back('{1'b1, 1'b0, cyc + 3});
    tick();
    st2 = 1'b0; a2 = 2'b11; b2 = 2'b11;
    chk("w2_busy_c1", 32'(busy2), 32'd1);
    tick();
    chk("w2_busy_c2", 32'(busy2), 32'd1);
    tick();
    chk("w2_busy_done", 32'(busy2), 32'd0);
    chk("w2_valid_done", 32'(v2), 32'd1);
    tick();
    chk("w2_valid_pulse", 32'(v2), 32'd0);
    repeat (2) tick();

    issue2(2'b11, 2'b00, 1'b0);
    issue2(2'b00, 2'b11, 1'b1);

    // WIDTH=8 extremes and a few mixed-sign cases
    issue8(8'h80, 8'h7F, 1'b0, 1'b0);
    issue8(8'h7F, 8'h80, 1'b1, 1'b0);
    issue8(8'h5A, 8'h5A, 1'b0, 1'b1);
    issue8(8'h01, 8'h02, 1'b0, 1'b0);
    issue8(8'hFF, 8'hFE, 1'b1, 1'b0);

    // Reset during the 4th SHIFT cycle aborts without a VALID
    a8 = 8'h00; b8 = 8'h7F; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    repeat (3) tick();
    rst8 = 1'b1;
    tick();
    chk("abort_busy8", 32'(busy8), 32'd0);
    chk("abort_valid8", 32'(v8), 32'd0);
    chk("abort_o8", 32'(o8), 32'd0);
    rst8 = 1'b0;
    repeat (12) tick();
    issue8(8'h7F, 8'h80, 1'b1, 1'b0);

    // START mid-SHIFT with other operands must be ignored
    a8 = 8'h01; b8 = 8'h02; st8 = 1'b1;
    q8.push_back('{1'b0, 1'b0, cyc + 9});
    tick();
    st8 = 1'b0;
    repeat (3) tick();
    a8 = 8'h7F; b8 = 8'h80; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    repeat (12) tick();

    // START held: one result every 9 clocks, operands swapped in each DONE cycle
    st8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a8 = bba[k]; b8 = bbb[k];
      q8.push_back('{bbo[k], 1'b0, cyc + 9});
      tick();
      if (k == 2) st8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      repeat (8) tick();
    end
    repeat (6) tick();

    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
